// File: rtl/wave_pkg.sv
// Shared definitions for the double-buffered 512x8 wave RAM (writer and display sides).
package wave_pkg;

    localparam int WAVE_SAMPLES = 256;
    localparam int WAVE_ADDR_W  = 9;
    localparam int WAVE_DATA_W  = 8;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } wave_state_e;

    // Top byte of a signed sample, re-biased to offset-binary for the plotter.
    function automatic logic [WAVE_DATA_W-1:0] to_offset_binary(input logic [15:0] s);
        return {~s[15], s[14:8]};
    endfunction

endpackage

// File: rtl/wave_capture_if.sv
// Sample-stream and wave-RAM write-port bundle; master = capture side, slave = stream/RAM side.
interface wave_capture_if;
    import wave_pkg::*;

    logic                   new_sample_ready;
    logic [15:0]            new_sample_in;
    logic                   wave_display_idle;
    logic [WAVE_ADDR_W-1:0] write_address;
    logic                   write_enable;
    logic [WAVE_DATA_W-1:0] write_sample;
    logic                   read_index;

    modport master (
        input  new_sample_ready, new_sample_in, wave_display_idle,
        output write_address, write_enable, write_sample, read_index
    );

    modport slave (
        output new_sample_ready, new_sample_in, wave_display_idle,
        input  write_address, write_enable, write_sample, read_index
    );

endinterface

// File: rtl/wave_trigger.sv
// Positive-going zero-crossing detector: pulses when the sign goes from negative to non-negative.
module wave_trigger (
    input  logic clk,
    input  logic reset,
    input  logic sample_ready,
    input  logic sample_msb,
    output logic trigger
);

    logic prev_msb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prev_msb <= 1'b0;
        else if (sample_ready)
            prev_msb <= sample_msb;
    end

    assign trigger = sample_ready & prev_msb & ~sample_msb;

endmodule

// File: rtl/wave_capture.sv
// Wave RAM writer: arms on a positive zero crossing, fills the hidden half, swaps on display idle.
// Optional decimation of written samples when WAVE_CAPTURE_DECIMATE_EN is defined.
module wave_capture
    import wave_pkg::*;
#(
    parameter int DECIM_LOG2 = 0
) (
    input  logic           clk,
    input  logic           reset,
    wave_capture_if.master bus
);

    localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

`ifdef WAVE_CAPTURE_DECIMATE_EN
    localparam logic [CW-1:0] DECIM_MASK = CW'((1 << DECIM_LOG2) - 1);
`else
    localparam logic [CW-1:0] DECIM_MASK = '0;
`endif

    wave_state_e            state, state_d;
    logic [7:0]             index, index_d;
    logic [CW-1:0]          decim_cnt, decim_cnt_d;
    logic                   read_index, read_index_d;
    logic                   we, we_d;
    logic [WAVE_ADDR_W-1:0] addr, addr_d;
    logic [WAVE_DATA_W-1:0] data, data_d;
    logic                   trigger;
    logic                   decim_hit;

    wave_trigger u_trigger (
        .clk          (clk),
        .reset        (reset),
        .sample_ready (bus.new_sample_ready),
        .sample_msb   (bus.new_sample_in[15]),
        .trigger      (trigger)
    );

    assign decim_hit = (decim_cnt & DECIM_MASK) == '0;

    always_comb begin
        state_d      = state;
        index_d      = index;
        decim_cnt_d  = decim_cnt;
        read_index_d = read_index;
        we_d         = 1'b0;
        addr_d       = addr;
        data_d       = data;
        case (state)
            ARMED: begin
                if (trigger) begin
                    state_d     = ACTIVE;
                    index_d     = '0;
                    decim_cnt_d = '0;
                end
            end
            ACTIVE: begin
                if (bus.new_sample_ready) begin
                    decim_cnt_d = decim_cnt + 1'b1;
                    if (decim_hit) begin
                        we_d    = 1'b1;
                        addr_d  = {~read_index, index};
                        data_d  = to_offset_binary(bus.new_sample_in);
                        index_d = index + 1'b1;
                        if (index == 8'(WAVE_SAMPLES - 1))
                            state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.wave_display_idle) begin
                    read_index_d = ~read_index;
                    state_d      = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARMED;
            index      <= '0;
            decim_cnt  <= '0;
            read_index <= 1'b0;
            we         <= 1'b0;
            addr       <= '0;
            data       <= '0;
        end else begin
            state      <= state_d;
            index      <= index_d;
            decim_cnt  <= decim_cnt_d;
            read_index <= read_index_d;
            we         <= we_d;
            addr       <= addr_d;
            data       <= data_d;
        end
    end

    assign bus.write_enable  = we;
    assign bus.write_address = addr;
    assign bus.write_sample  = data;
    assign bus.read_index    = read_index;

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture against a per-sample behavioural model.
module tb_wave_capture;

`ifdef WAVE_CAPTURE_DECIMATE_EN
    localparam int TB_DECIM = 1;
`else
    localparam int TB_DECIM = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wave_capture_if bus();

    wave_capture #(.DECIM_LOG2(TB_DECIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int failures = 0;
    int wr_seen = 0;

    // Model: phase 0 = waiting for crossing, 1 = filling, 2 = holding for display
    int         ph;
    int         nwr;
    int         nseen;
    bit         prev;
    bit         ri;
    logic       exp_we;
    logic [8:0] exp_addr;
    logic [7:0] exp_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; nwr = 0; nseen = 0; prev = 0; ri = 0;
        exp_we = 0; exp_addr = '0; exp_data = '0;
    endtask

    task automatic model_step(input bit rdy, input logic [15:0] s, input bit idle);
        int ph0;
        ph0 = ph;
        exp_we = 0;
        if (ph0 == 2 && idle) begin
            ri = !ri;
            ph = 0;
        end
        if (rdy) begin
            if (ph0 == 0 && prev && !s[15]) begin
                ph = 1; nwr = 0; nseen = 0;
            end else if (ph0 == 1) begin
                if (nseen % (1 << TB_DECIM) == 0) begin
                    exp_we   = 1;
                    exp_addr = 9'((ri ? 0 : 256) + nwr);
                    exp_data = 8'((s ^ 16'h8000) >> 8);
                    nwr++;
                    if (nwr == 256) ph = 2;
                end
                nseen++;
            end
            prev = s[15];
        end
    endtask

    task automatic check_outputs();
        check_eq("write_enable", 32'(bus.write_enable), 32'(exp_we));
        check_eq("write_address", 32'(bus.write_address), 32'(exp_addr));
        check_eq("write_sample", 32'(bus.write_sample), 32'(exp_data));
        check_eq("read_index", 32'(bus.read_index), 32'(ri));
    endtask

    task automatic step(input bit rdy, input logic [15:0] s, input bit idle);
        bus.new_sample_ready  = rdy;
        bus.new_sample_in     = s;
        bus.wave_display_idle = idle;
        @(posedge clk);
        #1;
        model_step(rdy, s, idle);
        if (bus.write_enable) wr_seen++;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = '0;
        bus.wave_display_idle = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        reset = 1'b0;
    endtask

    task automatic fire_trigger();
        step(1'b1, 16'h8000, 1'b0);
        step(1'b1, 16'h0100, 1'b0);
    endtask

    task automatic random_capture(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b0, 16'($urandom()), 1'($urandom_range(0, 1)));
            step(1'b1, 16'($urandom()), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        int base;
        model_reset();

        // Trigger then ramp: full buffer into upper half, nothing more while waiting
        do_reset();
        base = wr_seen;
        fire_trigger();
        for (int i = 0; i < (256 << TB_DECIM); i++) begin
            if ($urandom_range(0, 4) == 0) step(1'b0, 16'h5555, 1'b0);
            step(1'b1, 16'(i), 1'b0);
        end
        for (int i = 0; i < 20; i++) step(1'b1, (i % 2 == 0) ? 16'h8000 : 16'h0100, 1'b0);
        check_eq("ramp_write_count", 32'(wr_seen - base), 32'd256);

        // Idle swaps halves; next capture goes to the lower half
        step(1'b0, 16'h0000, 1'b1);
        check_eq("swap_read_index", 32'(bus.read_index), 32'd1);
        step(1'b0, 16'h0000, 1'b1);
        base = wr_seen;
        fire_trigger();
        random_capture(256 << TB_DECIM);
        check_eq("lower_write_count", 32'(wr_seen - base), 32'd256);
        step(1'b0, 16'h0000, 1'b1);
        fire_trigger();
        random_capture(256 << TB_DECIM);
        step(1'b0, 16'h0000, 1'b1);

        // Partial capture into the lower half, then asynchronous reset mid-cycle
        base = wr_seen;
        fire_trigger();
        for (int i = 0; i < 2000 && (wr_seen - base) < 100; i++)
            step(1'b1, 16'($urandom()), 1'b0);
        check_eq("partial_write_count", 32'(wr_seen - base), 32'd100);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1 reset = 1'b0;
        fire_trigger();
        step(1'b1, 16'h4000, 1'b0);
        check_eq("restart_address", 32'(bus.write_address), 32'h100);
        for (int i = 0; i < 10; i++) step(1'b1, 16'($urandom()), 1'b0);

        // Non-negative stream never arms
        do_reset();
        base = wr_seen;
        for (int i = 0; i < 60; i++) step(1'b1, 16'h1234, 1'b0);
        check_eq("no_trigger_writes", 32'(wr_seen - base), 32'd0);

        // Conversion corners
        do_reset();
        fire_trigger();
        step(1'b1, 16'h7FFF, 1'b0);
`ifndef WAVE_CAPTURE_DECIMATE_EN
        check_eq("conv_7fff", 32'(bus.write_sample), 32'hFF);
`endif
        step(1'b0, 16'h0000, 1'b0);
        check_eq("strobe_width", 32'(bus.write_enable), 32'd0);
        step(1'b1, 16'h8000, 1'b0);
        step(1'b1, 16'hFF00, 1'b0);
`ifndef WAVE_CAPTURE_DECIMATE_EN
        check_eq("conv_ff00", 32'(bus.write_sample), 32'h7F);
`endif

        // Random soak with free-running idle
        do_reset();
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 2) != 0), 16'($urandom()), $urandom_range(0, 7) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
